// File: rtl/uart_rx_parity_ctrl_pkg.sv
// Shared UART definitions: FSM state encodings and the default baud divisor,
// common to the receiver and the matching transmitter.
package uart_rx_parity_ctrl_pkg;

  localparam int UART_BAUD_DIV_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Parity bit the sender should have put on the line for this byte.
  function automatic logic uart_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_parity_ctrl_baud_tick.sv
// Baud counter: runs 0..BAUD_DIV-1 and flags the mid-bit and end-of-bit counts.
// A synchronous clear restarts the count so every state begins its own bit period.
module uart_baud_tick #(
  parameter int BAUD_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic mid,
  output logic full
);

  localparam int CW = $clog2(BAUD_DIV);

  logic [CW-1:0] cnt_reg;

  assign mid  = (cnt_reg == CW'(BAUD_DIV / 2 - 1));
  assign full = (cnt_reg == CW'(BAUD_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr || full) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_parity_ctrl.sv
// UART receiver, 8 data bits LSB first, optional even/odd parity, one stop bit.
// Every completed frame is delivered with VALID; the error flags qualify it.
module uart_rx_parity_ctrl
  import uart_rx_parity_ctrl_pkg::*;
#(
  parameter int BAUD_DIV   = UART_BAUD_DIV_DEFAULT,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  uart_state_e state_reg, state_next;
  logic       sync1_reg, rx_s_reg;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic       perr_reg, perr_next;
  logic [7:0] data_out_reg, data_out_next;
  logic       valid_reg, valid_next;
  logic       parity_err_reg, parity_err_next;
  logic       frame_err_reg, frame_err_next;
  logic       baud_clr, baud_mid, baud_full;

  // Restart the bit period whenever a new state is entered, and hold it in IDLE.
  assign baud_clr = (state_reg == ST_IDLE) || (state_next != state_reg);

  uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (baud_clr),
    .mid  (baud_mid),
    .full (baud_full)
  );

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    perr_next       = perr_reg;
    data_out_next   = data_out_reg;
    valid_next      = 1'b0;
    parity_err_next = parity_err_reg;
    frame_err_next  = frame_err_reg;
    case (state_reg)
      ST_IDLE: begin
        bit_cnt_next = 3'd0;
        perr_next    = 1'b0;
        if (!rx_s_reg) state_next = ST_START;
      end
      ST_START: begin
        // A start bit that is gone by mid-bit is treated as a glitch.
        if (baud_mid) state_next = rx_s_reg ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (baud_full) begin
          shift_next[bit_cnt_reg] = rx_s_reg;
          if (bit_cnt_reg == 3'd7) begin
            state_next = PARITY_EN ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_full) begin
          perr_next  = (rx_s_reg != uart_parity(shift_reg, PARITY_ODD));
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (baud_full) begin
          state_next      = ST_IDLE;
          valid_next      = 1'b1;
          data_out_next   = shift_reg;
          parity_err_next = PARITY_EN && perr_reg;
          frame_err_next  = !rx_s_reg;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg      <= 1'b1;
      rx_s_reg       <= 1'b1;
      state_reg      <= ST_IDLE;
      bit_cnt_reg    <= 3'd0;
      shift_reg      <= 8'h00;
      perr_reg       <= 1'b0;
      data_out_reg   <= 8'h00;
      valid_reg      <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      sync1_reg      <= rx;
      rx_s_reg       <= sync1_reg;
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      perr_reg       <= perr_next;
      data_out_reg   <= data_out_next;
      valid_reg      <= valid_next;
      parity_err_reg <= parity_err_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  assign data_out   = data_out_reg;
  assign valid      = valid_reg;
  assign parity_err = parity_err_reg;
  assign frame_err  = frame_err_reg;
  assign busy       = (state_reg != ST_IDLE);

endmodule

// File: doc/uart_rx_parity_ctrl.md
UART_RX_PARITY_CTRL -- requirements
Module: uart_rx_parity_ctrl

Interface
REQ-001 Parameter BAUD_DIV, default 16: CLK cycles per serial bit; legal values are even and >= 4.
REQ-002 Parameter PARITY_EN, default 1: 1 = frame carries a parity bit after D7; 0 = no parity bit.
REQ-003 Parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity.
REQ-004 CLK  input  1  sole clock; all logic on the rising edge.
REQ-005 RST_N  input  1  synchronous, active-low reset.
REQ-006 RX  input  1  asynchronous serial line; idles high.
REQ-007 DATA_OUT  output  8  last received byte, LSB first on the line.
REQ-008 VALID  output  1  one-cycle pulse when a frame completes.
REQ-009 PARITY_ERR  output  1  qualifies VALID: received parity bit mismatched.
REQ-010 FRAME_ERR  output  1  qualifies VALID: stop bit sampled low.
REQ-011 BUSY  output  1  high whenever the state is not IDLE.

Function
REQ-012 RX shall pass through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-013 FSM states shall be IDLE, START, DATA, PARITY, STOP.
REQ-014 IDLE -> START shall occur when rx_s = 0; the bit counter clears and the baud counter loads 0.
REQ-015 START: at baud count BAUD_DIV/2-1 (mid start bit), rx_s = 0 -> DATA with baud counter reset; rx_s = 1 -> IDLE (glitch, no VALID).
REQ-016 DATA: every BAUD_DIV cycles, sample rx_s into bit[bit_cnt]; after bit 7, go to PARITY if PARITY_EN, else STOP.
REQ-017 PARITY: sample one bit after BAUD_DIV cycles; expected = (XOR of 8 data bits) XOR PARITY_ODD; mismatch sets the internal error flag.
REQ-018 STOP: sample after BAUD_DIV cycles; rx_s = 0 sets the frame error flag; state returns to IDLE.
REQ-019 VALID shall assert in the cycle after the stop-bit sample, for exactly one cycle.
REQ-020 DATA_OUT, PARITY_ERR and FRAME_ERR shall update in that same cycle and hold until the next VALID.
REQ-021 Frames are still delivered with VALID=1 on parity or frame error; no frame is dropped.
REQ-022 Baud counter width shall be clog2(BAUD_DIV); bit counter 3 bits; neither counter shall wrap outside its state.
REQ-023 If rx_s is already low in the VALID cycle, IDLE shall detect the next start bit on the following cycle, supporting back-to-back frames.
REQ-024 If stop bit = 0 and the line stays low, the block shall return to IDLE and treat the continued low as a new start candidate.
REQ-025 With PARITY_EN = 0, PARITY_ERR shall stay 0.

Reset
REQ-026 When RST_N = 0 at a CLK edge: state = IDLE, counters = 0, synchronizer flops = 1, DATA_OUT = 8'h00, VALID = 0, PARITY_ERR = 0, FRAME_ERR = 0, BUSY = 0.
REQ-027 Reset mid-frame shall abort the frame with no VALID; reception resumes from IDLE on the first cycle after RST_N = 1.

Structure
REQ-028 A shared UART package or include shall hold the state encodings (3-bit) and the default BAUD_DIV, for reuse by the matching transmitter.
REQ-029 One sub-module, uart_baud_tick, shall provide the baud counter with clear input and mid/full tick outputs; all other logic stays in uart_rx_parity_ctrl.

Verification (BAUD_DIV = 16, PARITY_EN = 1, PARITY_ODD = 0 unless noted)
REQ-030 Frame 0xA5, parity 0, stop 1 -> VALID pulse once, DATA_OUT = 0xA5, PARITY_ERR = 0, FRAME_ERR = 0, VALID 2+16*10.5+1 cycles after the start edge (±1).
REQ-031 Frame 0xA5, parity 1 -> VALID, DATA_OUT = 0xA5, PARITY_ERR = 1; repeat with PARITY_ODD = 1, parity 1 -> PARITY_ERR = 0.
REQ-032 Frame 0x3C with stop bit 0 -> VALID, DATA_OUT = 0x3C, FRAME_ERR = 1.
REQ-033 RX low pulse of 5 cycles -> BUSY pulses, state returns to IDLE, no VALID.
REQ-034 RST_N low for 1 cycle during bit 4 of a frame -> no VALID, all outputs at reset values; next full frame 0x81 -> DATA_OUT = 0x81.
REQ-035 Two back-to-back frames 0x55 then 0xFF, no idle gap -> two VALID pulses with the correct data and no errors.
